// File: rtl/pipe_pkg.sv
// Shared field layout of the execute->memory bus and the memory->writeback bus,
// plus the memory-stage FSM state type.
package pipe_pkg;

  // Execute-stage bus: {dest reg, isLoad, isMemWrite, isWrite, value, address}
  localparam int EX_ADDR_LSB   = 0;
  localparam int EX_VAL_LSB    = 8;
  localparam int EX_ISWRITE    = 72;
  localparam int EX_ISMEMWRITE = 73;
  localparam int EX_ISLOAD     = 74;
  localparam int EX_REG_LSB    = 75;
  localparam int EX_BUS_W      = 79;

  // Writeback bus: {dest reg, isWrite, value}
  localparam int WB_VAL_LSB    = 0;
  localparam int WB_ISWRITE    = 64;
  localparam int WB_REG_LSB    = 65;
  localparam int WB_BUS_W      = 69;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } mem_state_t;

endpackage

// File: rtl/memory_access_stage_data_mem.sv
// Single-port data memory: synchronous write, registered read.
module data_mem #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Store on write enable; capture read data on read enable.
  // NOTE: the array has no reset branch on purpose -- clearing every word would
  // turn the array into a huge flop bank instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata       <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: executes stores/loads against the data memory
// and drives a registered writeback bus. Loads take one extra (stall) cycle.
module memory_access_stage
  import pipe_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int REG_W     = 4,
  parameter int MEM_DEPTH = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [EX_BUS_W-1:0] ex_bus,
  input  logic                ex_valid,
  output logic                stall_out,
  output logic [WB_BUS_W-1:0] wb_bus,
  output logic                wb_valid,
  output logic                err
);

  mem_state_t          r_state;
  mem_state_t          w_state_nxt;
  logic [WB_BUS_W-1:0] r_wb_bus;
  logic [WB_BUS_W-1:0] w_wb_bus_nxt;
  logic                r_wb_valid;
  logic                w_wb_valid_nxt;
  logic                r_err;
  logic                w_err_nxt;
  logic [REG_W-1:0]    r_ld_reg;
  logic                r_ld_iswrite;
  logic                w_ld_latch;
  logic                w_mem_we;
  logic                w_mem_re;
  logic [DATA_W-1:0]   w_rdata;

  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_val;
  logic [REG_W-1:0]    w_reg;
  logic                w_iswrite;
  logic                w_ismemwrite;
  logic                w_isload;

  assign w_addr       = ex_bus[EX_ADDR_LSB +: ADDR_W];
  assign w_val        = ex_bus[EX_VAL_LSB +: DATA_W];
  assign w_reg        = ex_bus[EX_REG_LSB +: REG_W];
  assign w_iswrite    = ex_bus[EX_ISWRITE];
  assign w_ismemwrite = ex_bus[EX_ISMEMWRITE];
  assign w_isload     = ex_bus[EX_ISLOAD];

  // State register.
  // NOTE: sequential state always uses non-blocking assignment so every flop
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, next writeback value and memory strobes.
  // NOTE: every signal gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_wb_bus_nxt   = r_wb_bus;
    w_wb_valid_nxt = 1'b0;
    w_err_nxt      = r_err;
    w_ld_latch     = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_re       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ex_valid) begin
          if (w_isload && !w_ismemwrite) begin
            w_mem_re    = 1'b1;
            w_ld_latch  = 1'b1;
            w_state_nxt = READ;
          end else begin
            // Plain ALU result or store; load+store together is illegal and
            // is executed as a store while raising the sticky error.
            w_mem_we                               = w_ismemwrite & rst_n;
            w_wb_bus_nxt[WB_VAL_LSB +: DATA_W]     = w_val;
            w_wb_bus_nxt[WB_ISWRITE]               = w_iswrite;
            w_wb_bus_nxt[WB_REG_LSB +: REG_W]      = w_reg;
            w_wb_valid_nxt                         = 1'b1;
            if (w_isload) w_err_nxt = 1'b1;
          end
        end
      end
      READ: begin
        w_wb_bus_nxt[WB_VAL_LSB +: DATA_W] = w_rdata;
        w_wb_bus_nxt[WB_ISWRITE]           = r_ld_iswrite;
        w_wb_bus_nxt[WB_REG_LSB +: REG_W]  = r_ld_reg;
        w_wb_valid_nxt                     = 1'b1;
        w_state_nxt                        = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Writeback bus, error flag and load destination latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wb_bus     <= '0;
      r_wb_valid   <= 1'b0;
      r_err        <= 1'b0;
      r_ld_reg     <= '0;
      r_ld_iswrite <= 1'b0;
    end else begin
      r_wb_bus   <= w_wb_bus_nxt;
      r_wb_valid <= w_wb_valid_nxt;
      r_err      <= w_err_nxt;
      if (w_ld_latch) begin
        r_ld_reg     <= w_reg;
        r_ld_iswrite <= w_iswrite;
      end
    end
  end

  data_mem #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_data_mem (
    .clk    (clk),
    .i_we   (w_mem_we),
    .i_re   (w_mem_re),
    .i_addr (w_addr),
    .i_wdata(w_val),
    .o_rdata(w_rdata)
  );

  assign stall_out = (r_state == READ);
  assign wb_bus    = r_wb_bus;
  assign wb_valid  = r_wb_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios plus random
// traffic, compared each cycle against a transaction-level model.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [78:0] ex_bus;
  logic        ex_valid;
  logic        stall_out;
  logic [68:0] wb_bus;
  logic        wb_valid;
  logic        err;

  int errors = 0;
  int checks = 0;

  // Behavioural model: memory image, one pending load, sticky error.
  logic [63:0] m_mem [256];
  bit          m_known [256];
  bit          m_pend = 1'b0;
  logic [7:0]  m_addr;
  logic [3:0]  m_reg;
  bit          m_wr;
  bit          m_wbv = 1'b0;
  logic [68:0] m_wb = '0;
  bit          m_wb_known = 1'b1;
  bit          m_err = 1'b0;

  always #5 clk = ~clk;

  memory_access_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ex_bus   (ex_bus),
    .ex_valid (ex_valid),
    .stall_out(stall_out),
    .wb_bus   (wb_bus),
    .wb_valid (wb_valid),
    .err      (err)
  );

  function automatic logic [78:0] mk(logic [7:0] a, logic [63:0] v, bit wr,
                                     bit mw, bit ld, logic [3:0] rg);
    return {rg, ld, mw, wr, v, a};
  endfunction

  task automatic check(string name, logic [68:0] got, logic [68:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply the rules for one clock edge to the model, using the current inputs.
  task automatic model_step();
    logic [7:0]  a;
    logic [63:0] v;
    a = ex_bus[7:0];
    v = ex_bus[71:8];
    if (!rst_n) begin
      m_pend = 1'b0; m_wbv = 1'b0; m_wb = '0; m_wb_known = 1'b1; m_err = 1'b0;
    end else if (m_pend) begin
      m_wb = {m_reg, m_wr, m_mem[m_addr]};
      m_wb_known = m_known[m_addr];
      m_wbv = 1'b1;
      m_pend = 1'b0;
    end else if (ex_valid) begin
      if (ex_bus[74] && !ex_bus[73]) begin
        m_pend = 1'b1; m_addr = a; m_reg = ex_bus[78:75]; m_wr = ex_bus[72];
        m_wbv = 1'b0;
      end else begin
        if (ex_bus[73]) begin
          m_mem[a] = v;
          m_known[a] = 1'b1;
        end
        if (ex_bus[74]) m_err = 1'b1;
        m_wb = {ex_bus[78:75], ex_bus[72], v};
        m_wb_known = 1'b1;
        m_wbv = 1'b1;
      end
    end else begin
      m_wbv = 1'b0;
    end
  endtask

  // One clock: advance the model, let the edge pass, compare all outputs.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("wb_valid", {68'b0, wb_valid}, {68'b0, m_wbv});
    check("stall_out", {68'b0, stall_out}, {68'b0, m_pend});
    check("err", {68'b0, err}, {68'b0, m_err});
    if (m_wb_known) check("wb_bus", wb_bus, m_wb);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    rst_n = 1'b0; ex_valid = 1'b0; ex_bus = '0;
    #2;
    tick();

    // Seed mem[5], then hold reset 3 cycles with a conflicting store.
    rst_n = 1'b1; ex_valid = 1'b1; ex_bus = mk(8'd5, 64'h1111, 1, 1, 0, 4'h1);
    tick();
    rst_n = 1'b0; ex_bus = mk(8'd5, 64'h5555, 1, 1, 0, 4'h1);
    repeat (3) tick();
    check("rst_wb_valid", {68'b0, wb_valid}, 69'd0);
    check("rst_wb_bus", wb_bus, 69'd0);
    check("rst_stall", {68'b0, stall_out}, 69'd0);
    check("rst_err", {68'b0, err}, 69'd0);
    rst_n = 1'b1; ex_bus = mk(8'd5, 64'h0, 1, 0, 1, 4'h1);
    tick();
    ex_valid = 1'b0;
    tick();
    check("rst_no_write", wb_bus, {4'h1, 1'b1, 64'h1111});

    // ALU passthrough.
    ex_valid = 1'b1; ex_bus = mk(8'h40, 64'h3, 1, 0, 0, 4'hD);
    tick();
    check("pass_bus", wb_bus, {4'hD, 1'b1, 64'h3});
    check("pass_stall", {68'b0, stall_out}, 69'd0);

    // Store then load, junk during READ, then junk accepted as held instruction.
    ex_bus = mk(8'h10, 64'hDEADBEEF, 0, 1, 0, 4'h0);
    tick();
    ex_bus = mk(8'h10, 64'h0, 1, 0, 1, 4'h2);
    tick();
    check("load_stall", {68'b0, stall_out}, 69'd1);
    ex_bus = mk(8'h10, 64'hBAD, 1, 1, 0, 4'h7);
    tick();
    check("load_bus", wb_bus, {4'h2, 1'b1, 64'hDEADBEEF});
    check("load_valid", {68'b0, wb_valid}, 69'd1);
    tick();
    check("held_bus", wb_bus, {4'h7, 1'b1, 64'hBAD});
    ex_valid = 1'b0;
    tick();
    check("valid_drop", {68'b0, wb_valid}, 69'd0);

    // Illegal load+store at the top address.
    ex_valid = 1'b1; ex_bus = mk(8'hFF, 64'h7, 1, 1, 1, 4'h5);
    tick();
    check("illegal_err", {68'b0, err}, 69'd1);
    check("illegal_stall", {68'b0, stall_out}, 69'd0);
    ex_bus = mk(8'hFF, 64'h0, 0, 0, 1, 4'h9);
    tick();
    tick();
    check("load_nowrite", wb_bus, {4'h9, 1'b0, 64'h7});
    ex_valid = 1'b0;
    repeat (2) tick();
    check("err_sticky", {68'b0, err}, 69'd1);

    // Random traffic concentrated on a few addresses to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      if (m_pend) begin
        ex_valid = 1'($urandom_range(0, 1));
        ex_bus   = 79'({$urandom, $urandom, $urandom});
      end else begin
        ex_valid = ($urandom_range(0, 3) != 0);
        ex_bus   = mk(($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15)),
                      {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)));
      end
      tick();
    end

    // Reset during READ aborts the load.
    ex_valid = 1'b1; ex_bus = mk(8'h10, 64'h0, 1, 0, 1, 4'h3);
    tick();
    check("abort_stall", {68'b0, stall_out}, 69'd1);
    rst_n = 1'b0; ex_valid = 1'b0;
    tick();
    check("abort_valid", {68'b0, wb_valid}, 69'd0);
    check("abort_idle", {68'b0, stall_out}, 69'd0);
    rst_n = 1'b1;
    tick();
    check("abort_no_pulse", {68'b0, wb_valid}, 69'd0);
    check("abort_err_clr", {68'b0, err}, 69'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Pipeline stage directly downstream of the execution unit (alu).
- Consumes alu's 79-bit Address/Value/RegAddress/isLoad/isMemWrite/isWrite bus.
- Performs data-memory stores and loads against a 256 x 64 synchronous data memory.
- Presents a registered writeback bus to the register-file write stage; stalls upstream for one cycle on loads.

Parameters:
- ADDR_W, 8, data-memory address width; must match alu address field.
- DATA_W, 64, data word width.
- REG_W, 4, destination register index width.
- MEM_DEPTH, 256, data-memory words (2**ADDR_W).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- ex_bus  input  79  from alu: [7:0] address, [71:8] value, [72] isWrite, [73] isMemWrite, [74] isLoad, [78:75] dest reg.
- ex_valid  input  1  ex_bus holds a live instruction this cycle.
- stall_out  output  1  upstream must hold ex_bus/ex_valid unchanged while high.
- wb_bus  output  69  [63:0] value, [64] isWrite, [68:65] dest reg.
- wb_valid  output  1  wb_bus is valid for exactly this cycle.
- err  output  1  sticky illegal-encoding flag.

Behaviour:
- Reset is synchronous, active-low: on rising clk with rst_n=0, state <= IDLE, wb_valid <= 0, wb_bus <= 0, err <= 0.
- stall_out is combinational from state, so it is 0 immediately after reset.
- Memory contents are not reset. No memory write occurs on a reset cycle.
- FSM, two states:
  - IDLE: stall_out=0; instruction accepted on any edge with ex_valid=1.
  - READ: stall_out=1; ex_bus/ex_valid ignored.
- IDLE, ex_valid=0: wb_valid <= 0; wb_bus holds its previous value.
- IDLE, ex_valid=1, isLoad=0:
  - If isMemWrite=1: mem[address] <= value on this edge.
  - wb_bus <= {reg, isWrite, value}; wb_valid <= 1. Latency 1 cycle.
- IDLE, ex_valid=1, isLoad=1, isMemWrite=0:
  - Read issued on this edge; latch reg and isWrite; state <= READ; wb_valid <= 0.
- READ:
  - Next edge: wb_bus <= {latched reg, latched isWrite, mem read data}; wb_valid <= 1; state <= IDLE.
  - Load latency 2 cycles; exactly one stall cycle.
- isLoad=1 and isMemWrite=1 together: treated as a store (no read, no stall); err <= 1, cleared only by reset.
- isLoad=1, isWrite=0: read still performed and wb_valid pulses; wb_bus[64]=0 so no register write.
- Store then load to the same address on consecutive accepted cycles: the load returns the newly stored value (write edge precedes read edge).
- Address is the full 8 bits, with no wrap logic needed: 255 is the last word.
- Reset asserted while in READ: load aborted, no wb_valid pulse, state IDLE.
- wb_valid never stays high two consecutive cycles for the same instruction.

Decomposition:
- Shared package pipe_pkg:
  - EX bus field offsets (EX_ADDR_LSB=0, EX_VAL_LSB=8, EX_ISWRITE=72, EX_ISMEMWRITE=73, EX_ISLOAD=74, EX_REG_LSB=75) and EX_BUS_W=79.
  - WB bus offsets and WB_BUS_W=69.
  - mem_state_t enum {IDLE, READ}.
- One sub-module: data_mem. Single port, synchronous write, registered read, DATA_W x MEM_DEPTH.

Test Plan:
- Reset: hold rst_n=0 3 cycles with ex_valid=1 store -> wb_valid=0, wb_bus=0, stall_out=0, err=0; mem[5] is not written.
- ALU passthrough: ex_valid=1, isWrite=1, reg=4'hD, value=64'h3 -> next cycle wb_valid=1, wb_bus={4'hD,1,64'h3}, stall_out stays 0.
- Store then load: store addr 8'h10, value 64'hDEADBEEF; next cycle load addr 8'h10, reg 4'h2, isWrite=1 -> stall_out=1 for one cycle, then wb_bus={4'h2,1,64'hDEADBEEF}, wb_valid one cycle.
- Stall hold: during the READ cycle drive a different ex_bus with ex_valid=1 -> it is ignored; the same held instruction is accepted the cycle after READ.
- Illegal encoding: isLoad=1, isMemWrite=1, addr 8'hFF, value 64'h7 -> mem[255]=7, no stall, err=1 and stays 1 until reset.
- Reset mid-load: load accepted, rst_n=0 during READ -> no wb_valid pulse, state IDLE, stall_out=0 the following cycle.
